cond_unit: RTL and testbench
============================

# cond_unit

Condition/flag unit that consumes the ALU's `AluFlags` output ({N,Z,C,V}) on the other side of the flag interface. It holds the architectural NZCV flag register, evaluates the instruction's 4-bit ARM condition field against the stored flags, and gates the datapath write enables (PC, register file, memory) for the single-cycle ARMv4 core. It sits between the control decoder and the ALU/register file. Optional performance counters track executed and squashed instructions.

## Interface
- `CNT_W`, 16, width of the executed/squashed counters.
- `clk` in 1, core clock; all state updates on the rising edge.
- `reset` in 1, synchronous, active-high.
- `InstrValid` in 1, the current instruction is real; 0 means bubble or fetch stall.
- `Cond` in 4, instruction bits [31:28].
- `AluFlags` in 4, {N,Z,C,V} from the ALU for the current instruction.
- `FlagW` in 2: [1] writes N,Z; [0] writes C,V.
- `PCS`, `RegW`, `MemW`, `NoWrite` in 1 each, unconditioned decoder requests. `NoWrite` is set for CMP/CMN/TST/TEQ.
- `CondEx` out 1, condition passed and `InstrValid`.
- `PCSrc`, `RegWrite`, `MemWrite` out 1 each, gated enables.
- `Flags` out 4, registered {N,Z,C,V}.
- `ExecCnt`, `SquashCnt` out CNT_W each, counters.

## Operation
- Condition decode, evaluated on registered `Flags` (never on `AluFlags`):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F: treated as fail (instruction squashed)
- `CondEx` = `InstrValid` & condpass.
- `PCSrc` = `PCS` & `CondEx`.
- `RegWrite` = `RegW` & `CondEx` & !`NoWrite`.
- `MemWrite` = `MemW` & `CondEx`.
- Flag register update:
  - N,Z ← `AluFlags`[3:2] when `FlagW`[1] & `CondEx`.
  - C,V ← `AluFlags`[1:0] when `FlagW`[0] & `CondEx`.
  - Each group holds independently.
- A failed-condition instruction modifies no flags and no architectural state.
- Counters, when enabled:
  - `ExecCnt` increments on each edge where `CondEx` = 1.
  - `SquashCnt` increments on each edge where `InstrValid` & !condpass.
  - Both wrap modulo 2^CNT_W with no saturation and no sticky overflow.
  - Bubbles (`InstrValid` = 0) count in neither counter.

## Timing
- Reset (synchronous): `Flags` = 4'b0000, `ExecCnt` = `SquashCnt` = 0. Gated outputs follow from those values and the inputs; with zero flags, EQ fails and NE passes.
- `reset` asserted together with valid flag-setting inputs: reset wins, and flags and counters are cleared on that edge.
- Gated outputs are combinational, 0-cycle latency from `Cond`/`InstrValid`/requests.
- Flag write latency is 1 cycle:
  - An instruction writing flags in cycle t is seen by the condition of the instruction in cycle t+1.
  - An instruction never conditions on its own `AluFlags`.
- Back-to-back flag writes: each edge takes the latest enabled group. A partial write (e.g. `FlagW` = 2'b10) leaves C,V at their prior values.
- No combinational path from `AluFlags` to any output.

## Configuration
- `COND_PERF_CNT_EN`
  - Defined: both counters and their increment logic are built as specified.
  - Undefined: the counter registers are not instantiated, `ExecCnt` and `SquashCnt` are tied to 0, and all other behaviour is identical.

## Test plan
- Reset, then `Cond` = 0 (EQ) and `Cond` = 1 (NE) with `InstrValid` = 1, `RegW` = 1 → `RegWrite` = 0 for EQ, 1 for NE; `Flags` = 0000.
- CMP-like instruction: `AluFlags` = 4'b0110, `FlagW` = 11, `NoWrite` = 1, `Cond` = E → `RegWrite` = 0, and `Flags` = 0110 next cycle. Then `Cond` = 0 with `PCS` = 1 → `PCSrc` = 1.
- Partial write: `Flags` = 1011, then `FlagW` = 10 with `AluFlags` = 0100 → `Flags` = 0111.
- Squash: `Flags` = 0000, `Cond` = 0, `FlagW` = 11, `AluFlags` = 1111, `MemW` = 1 → `MemWrite` = 0, `Flags` stays 0000, `SquashCnt` +1.
- Sweep all 16 `Cond` codes × 16 flag values against the decode list above. `Cond` = F always yields `CondEx` = 0; `InstrValid` = 0 yields all enables 0 and no counter change.
- With `COND_PERF_CNT_EN` and CNT_W = 4: 17 consecutive `Cond` = E valid cycles → `ExecCnt` = 1 (wrapped). Assert `reset` mid-run → `ExecCnt` = 0 on the next edge.

Source files
------------

// File: rtl/cond_unit.sv
// Condition/flag unit: NZCV register, ARM condition decode, gating of PC/reg/mem write enables.
// Optional execute/squash counters built only when COND_PERF_CNT_EN is defined.
module cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InstrValid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       AluFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] SquashCnt
);

  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       cond_pass;

  assign {flag_n, flag_z} = nz_q;
  assign {flag_c, flag_v} = cv_q;
  assign Flags            = {nz_q, cv_q};

  // Decode uses only the registered flags so AluFlags never reaches an output.
  always_comb begin
    cond_pass = 1'b0;
    unique case (Cond)
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = !flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = !flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = !flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = !flag_v;
      4'h8: cond_pass = flag_c & !flag_z;
      4'h9: cond_pass = !flag_c | flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = !flag_z & (flag_n == flag_v);
      4'hD: cond_pass = flag_z | (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      4'hF: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  assign CondEx   = InstrValid & cond_pass;
  assign PCSrc    = PCS & CondEx;
  assign RegWrite = RegW & CondEx & !NoWrite;
  assign MemWrite = MemW & CondEx;

  always_comb begin
    nz_d = nz_q;
    cv_d = cv_q;
    if (FlagW[1] && CondEx) nz_d = AluFlags[3:2];
    if (FlagW[0] && CondEx) cv_d = AluFlags[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nz_q <= 2'b00;
      cv_q <= 2'b00;
    end else begin
      nz_q <= nz_d;
      cv_q <= cv_d;
    end
  end

`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;
  logic             squash;

  assign squash = InstrValid & !cond_pass;

  // Plain wrap-around; no saturation or overflow flag.
  always_comb begin
    exec_cnt_d   = exec_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (CondEx) exec_cnt_d   = exec_cnt_q + 1'b1;
    if (squash) squash_cnt_d = squash_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exec_cnt_q   <= '0;
      squash_cnt_q <= '0;
    end else begin
      exec_cnt_q   <= exec_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign ExecCnt   = exec_cnt_q;
  assign SquashCnt = squash_cnt_q;
`else
  assign ExecCnt   = '0;
  assign SquashCnt = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: driver pushes expected outputs, negedge monitor pops and compares.
module tb_cond_unit;
  localparam int CW = 4;

  typedef struct packed {
    logic          ce;
    logic          pc;
    logic          rw;
    logic          mw;
    logic [3:0]    fl;
    logic [CW-1:0] ex;
    logic [CW-1:0] sq;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          InstrValid = 1'b0;
  logic [3:0]    Cond = 4'hE;
  logic [3:0]    AluFlags = 4'h0;
  logic [1:0]    FlagW = 2'b00;
  logic          PCS = 1'b0, RegW = 1'b0, MemW = 1'b0, NoWrite = 1'b0;
  logic          CondEx, PCSrc, RegWrite, MemWrite;
  logic [3:0]    Flags;
  logic [CW-1:0] ExecCnt, SquashCnt;

  cond_unit #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .InstrValid(InstrValid), .Cond(Cond),
    .AluFlags(AluFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .NoWrite(NoWrite), .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .Flags(Flags), .ExecCnt(ExecCnt), .SquashCnt(SquashCnt)
  );

  always #5 clk = ~clk;

  exp_t          sb_q[$];
  int            tests = 0;
  int            fails = 0;
  int            pushed = 0;
  int            popped = 0;
  logic [3:0]    m_flags = 4'h0;
  logic [CW-1:0] m_exec = '0;
  logic [CW-1:0] m_squash = '0;

  // Reference decode: ARM pairs each even code with its odd complement.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf & ~z;
      3'd5: base = ~(n ^ v);
      3'd6: base = ~z & ~(n ^ v);
      default: base = 1'b1;
    endcase
    return c[0] ? ~base : base;
  endfunction

  task automatic step(input logic rst, input logic vld, input logic [3:0] c,
                      input logic [3:0] af, input logic [1:0] fw, input logic pcs,
                      input logic rw, input logic mw, input logic nw);
    exp_t e;
    logic pass, ex;
    reset = rst; InstrValid = vld; Cond = c; AluFlags = af; FlagW = fw;
    PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
    pass = ref_pass(c, m_flags);
    ex   = vld & pass;
    e.ce = ex;
    e.pc = pcs & ex;
    e.rw = rw & ex & ~nw;
    e.mw = mw & ex;
    e.fl = m_flags;
`ifdef COND_PERF_CNT_EN
    e.ex = m_exec;
    e.sq = m_squash;
`else
    e.ex = '0;
    e.sq = '0;
`endif
    sb_q.push_back(e);
    pushed++;
    @(posedge clk);
    if (rst) begin
      m_flags = 4'h0; m_exec = '0; m_squash = '0;
    end else begin
      if (ex && fw[1]) m_flags[3:2] = af[3:2];
      if (ex && fw[0]) m_flags[1:0] = af[1:0];
      if (ex) m_exec = m_exec + 1'b1;
      if (vld && !pass) m_squash = m_squash + 1'b1;
    end
    #1;
  endtask

  // Load flags with an AL instruction writing both groups.
  task automatic set_flags(input logic [3:0] f);
    step(1'b0, 1'b1, 4'hE, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e, a;
      e = sb_q.pop_front();
      popped++;
      a = '{CondEx, PCSrc, RegWrite, MemWrite, Flags, ExecCnt, SquashCnt};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL outputs cond=%h vld=%b: got ce%b pc%b rw%b mw%b fl%b ex%0d sq%0d, want ce%b pc%b rw%b mw%b fl%b ex%0d sq%0d",
                 Cond, InstrValid, a.ce, a.pc, a.rw, a.mw, a.fl, a.ex, a.sq,
                 e.ce, e.pc, e.rw, e.mw, e.fl, e.ex, e.sq);
      end
    end
  end

  initial begin
    // Unchecked reset so the registers leave X before anything is compared.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, EQ fails and NE passes with zero flags.
    step(1'b0, 1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h1, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

    // CMP-like: sets flags 0110 but writes no register; then EQ branch taken.
    step(1'b0, 1'b1, 4'hE, 4'b0110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Partial write: N,Z only.
    set_flags(4'b1011);
    step(1'b0, 1'b1, 4'hE, 4'b0100, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Squashed flag-setting store leaves flags untouched.
    set_flags(4'b0000);
    step(1'b0, 1'b1, 4'h0, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back flag writes each seen by the next instruction only.
    step(1'b0, 1'b1, 4'hE, 4'b0001, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h6, 4'b1000, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'h4, 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);

    // Full sweep plus bubbles carrying requests and flag writes.
    for (int f = 0; f < 16; f++) begin
      set_flags(f[3:0]);
      for (int c = 0; c < 16; c++)
        step(1'b0, 1'b1, c[3:0], 4'hF - f[3:0], 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 4'hE, ~f[3:0], 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    end

    // Counter wrap: 17 executed instructions after reset.
    step(1'b1, 1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++)
      step(1'b0, 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'hF, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset beats a simultaneous flag-setting instruction.
    step(1'b1, 1'b1, 4'hE, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h1, 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);

    reset = 1'b0; InstrValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (sb_q.size() != 0 || popped != pushed) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d popped, %0d left, want %0d popped, 0 left",
               popped, sb_q.size(), pushed);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
